instr_sequencer: RTL



---
 rtl/instr_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32I datapath.
// Moore outputs only; a sticky FAULT state is entered on an illegal opcode or a handshake timeout.
module instr_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             RUN,
    output logic             IMEM_REQ,
    input  logic             IMEM_RDY,
    input  logic [31:0]      IMEM_DATA,
    output logic [31:0]      MEM_INST,
    output logic             INST_ENB,
    output logic             LSU_REQ,
    input  logic             LSU_RDY,
    output logic             REG_WE_GATE,
    output logic             PC_CLK,
    output logic             FAULT,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] INSTR_CNT
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [6:0]        opcode;
    logic              timeout_hit;
    logic              op_legal;
    logic              op_mem;
    logic              op_writes_rd;

    assign opcode = MEM_INST[6:0];

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h0F, 7'h73: op_legal = 1'b1;
            default:                          op_legal = 1'b0;
        endcase
    end

    always_comb begin
        op_writes_rd = 1'b0;
        case (opcode)
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33: op_writes_rd = 1'b1;
            default:                                         op_writes_rd = 1'b0;
        endcase
    end

    assign op_mem = (opcode == 7'h03) || (opcode == 7'h23);

    // The count reaches TIMEOUT on the cycle where wait_cnt still holds TIMEOUT-1.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = RUN ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (IMEM_RDY)         state_next = S_DECODE;
                else if (timeout_hit) state_next = S_FAULT;
            end
            S_DECODE: state_next = op_legal ? S_EXEC : S_FAULT;
            S_EXEC:   state_next = op_mem ? S_MEM : S_WB;
            S_MEM: begin
                if (LSU_RDY)          state_next = S_WB;
                else if (timeout_hit) state_next = S_FAULT;
            end
            S_WB:     state_next = RUN ? S_FETCH : S_IDLE;
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            MEM_INST  <= '0;
            INSTR_CNT <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (state == S_FETCH || state == S_MEM)
                wait_cnt <= wait_cnt + 1'b1;
            if (state == S_FETCH && IMEM_RDY)
                MEM_INST <= IMEM_DATA;
            if (state == S_WB)
                INSTR_CNT <= INSTR_CNT + 1'b1;
        end
    end

    assign STATE       = state;
    assign IMEM_REQ    = (state == S_FETCH);
    assign INST_ENB    = (state == S_DECODE);
    assign LSU_REQ     = (state == S_MEM);
    assign PC_CLK      = (state == S_WB);
    assign REG_WE_GATE = (state == S_WB) && op_writes_rd;
    assign FAULT       = (state == S_FAULT);

endmodule
